// File: rtl/vx_mem_responder_pkg.sv
// Shared types and helpers for the L2 memory-side responder.
// Default widths match the standard L2 line (64 bytes) and 8-bit tags.
package vx_mem_responder_pkg;

    localparam int MEM_DATA_SIZE = 64;
    localparam int MEM_TAG_WIDTH = 8;
    localparam int MEM_RSP_QUEUE = 4;

    typedef struct packed {
        logic [MEM_TAG_WIDTH-1:0]   tag;
        logic [MEM_DATA_SIZE*8-1:0] data;
    } mem_rsp_entry_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int MEM_RSP_CREDIT_W = credit_width(MEM_RSP_QUEUE);

endpackage

// File: rtl/vx_mem_responder_fifo.sv
// Response FIFO: registered head, pointer-based storage, no overflow guard
// (the responder's credit counter keeps it from ever filling past DEPTH).
module vx_mem_responder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-side slave for one L2 port: line storage, fixed-latency read path, credit-gated admission.
// Define MEM_RSP_WRITE_ACK_EN to make writes return a tagged zero-data acknowledgement.
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_SIZE  = MEM_DATA_SIZE,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
    parameter int NUM_LINES  = 1024,
    parameter int LATENCY    = 4,
    parameter int RSP_QUEUE  = MEM_RSP_QUEUE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    input  logic                   mem_req_rw,
    input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic [DATA_SIZE-1:0]   mem_req_byteen,
    input  logic [DATA_SIZE*8-1:0] mem_req_data,
    input  logic [TAG_WIDTH-1:0]   mem_req_tag,
    output logic                   mem_req_ready,
    output logic                   mem_rsp_valid,
    output logic [DATA_SIZE*8-1:0] mem_rsp_data,
    output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
    input  logic                   mem_rsp_ready,
    output logic                   busy
);
    localparam int DW = DATA_SIZE * 8;
    localparam int IW = $clog2(NUM_LINES);
    localparam int CW = credit_width(RSP_QUEUE);
    localparam int EW = TAG_WIDTH + DW;

    logic [DW-1:0]  mem_q [NUM_LINES];
    logic [IW-1:0]  idx;
    logic [CW-1:0]  pending_q, pending_d;
    logic           credit_ok, takes_credit, req_fire, rsp_fire;
    logic           in_valid, out_valid, fifo_empty;
    logic [EW-1:0]  in_entry, out_entry, head_entry;

    assign idx = mem_req_addr[IW-1:0];

    generate
        if (ADDR_WIDTH > IW) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:IW];
        end
    endgenerate

    assign credit_ok = (pending_q < CW'(RSP_QUEUE));

`ifdef MEM_RSP_WRITE_ACK_EN
    assign takes_credit  = 1'b1;
    assign mem_req_ready = credit_ok;
`else
    assign takes_credit  = ~mem_req_rw;
    assign mem_req_ready = mem_req_rw | credit_ok;
`endif

    assign req_fire = mem_req_valid & mem_req_ready;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;
    assign in_valid = req_fire & takes_credit;
    // Read data is taken before this edge's write, but only one request fires per cycle anyway.
    assign in_entry = {mem_req_tag, mem_req_rw ? {DW{1'b0}} : mem_q[idx]};

    always_ff @(posedge clk) begin
        if (req_fire && mem_req_rw) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (mem_req_byteen[b]) mem_q[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
            end
        end
    end

    // The FIFO write is the last latency stage, so only LATENCY-1 registers sit in front of it.
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign out_valid = in_valid;
            assign out_entry = in_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] pv_q;
            logic [EW-1:0]      pe_q [LATENCY-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pv_q <= '0;
                end else begin
                    pv_q[0] <= in_valid;
                    for (int i = 1; i < LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pe_q[0] <= in_entry;
                for (int i = 1; i < LATENCY - 1; i++) pe_q[i] <= pe_q[i-1];
            end

            assign out_valid = pv_q[LATENCY-2];
            assign out_entry = pe_q[LATENCY-2];
        end
    endgenerate

    vx_mem_responder_fifo #(
        .WIDTH (EW),
        .DEPTH (RSP_QUEUE)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (out_valid),
        .pop_i   (rsp_fire),
        .data_i  (out_entry),
        .data_o  (head_entry),
        .empty_o (fifo_empty)
    );

    assign mem_rsp_valid               = ~fifo_empty;
    assign {mem_rsp_tag, mem_rsp_data} = mem_rsp_valid ? head_entry : '0;

    assign pending_d = pending_q + CW'(in_valid) - CW'(rsp_fire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign busy = (pending_q != '0) | mem_req_valid;

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder against a queue-based timing model.
// Honors MEM_RSP_WRITE_ACK_EN the same way the design does.
module tb_vx_mem_responder;
    import vx_mem_responder_pkg::*;

    localparam int LAT = 4;
    localparam int QD  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid, mem_req_rw, mem_req_ready;
    logic [25:0]  mem_req_addr;
    logic [63:0]  mem_req_byteen;
    logic [511:0] mem_req_data;
    logic [7:0]   mem_req_tag;
    logic         mem_rsp_valid, mem_rsp_ready, busy;
    logic [511:0] mem_rsp_data;
    logic [7:0]   mem_rsp_tag;

    vx_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_rsp_entry_t e;
        int             due;
    } exp_t;

    exp_t         expq[$];
    logic [511:0] mm [1024];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: drive, check outputs against the model, then advance the model at the edge.
    task automatic cycle(input logic v, input logic rw, input logic [25:0] a,
                         input logic [63:0] be, input logic [511:0] d,
                         input logic [7:0] t, input logic rr, output logic fired);
        logic exp_ready, exp_rv, rf;
        int   idx;
        exp_t n;
        mem_req_valid = v; mem_req_rw = rw; mem_req_addr = a;
        mem_req_byteen = be; mem_req_data = d; mem_req_tag = t; mem_rsp_ready = rr;
        #1;
`ifdef MEM_RSP_WRITE_ACK_EN
        exp_ready = (expq.size() < QD);
`else
        exp_ready = rw | (expq.size() < QD);
`endif
        exp_rv = (expq.size() > 0) && (expq[0].due <= cyc);
        chk("req_ready", 512'(mem_req_ready), 512'(exp_ready));
        chk("rsp_valid", 512'(mem_rsp_valid), 512'(exp_rv));
        if (exp_rv) begin
            chk("rsp_tag", 512'(mem_rsp_tag), 512'(expq[0].e.tag));
            chk("rsp_data", mem_rsp_data, expq[0].e.data);
        end
        chk("busy", 512'(busy), 512'((expq.size() != 0) | v));
        fired = v & exp_ready;
        rf    = exp_rv & rr;
        @(posedge clk);
        if (rf) void'(expq.pop_front());
        if (fired) begin
            idx = int'(a[9:0]);
            if (rw) begin
`ifdef MEM_RSP_WRITE_ACK_EN
                n.e.tag = t; n.e.data = '0; n.due = cyc + LAT; expq.push_back(n);
`endif
                for (int b = 0; b < 64; b++) if (be[b]) mm[idx][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                n.e.tag = t; n.e.data = mm[idx]; n.due = cyc + LAT; expq.push_back(n);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic f;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, f);
    endtask

    initial begin
        logic         f;
        logic [511:0] pat, d;
        int           nfire, budget, start, fire_cyc;

        reset = 1'b1;
        mem_req_valid = 0; mem_req_rw = 0; mem_req_addr = '0; mem_req_byteen = '0;
        mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_rsp_valid", 512'(mem_rsp_valid), 512'(0));
        chk("rst_rsp_data", mem_rsp_data, '0);
        chk("rst_rsp_tag", 512'(mem_rsp_tag), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        reset = 1'b0;
        #1;
        chk("rst_req_ready", 512'(mem_req_ready), 512'(1));
        @(negedge clk);

        for (int i = 0; i < 16; i++) cycle(1, 1, 26'(i), '1, rnd512(), 8'h40, 1, f);
        idle(LAT + 2);

        // Write then read with exact-latency response.
        for (int b = 0; b < 64; b++) pat[b*8 +: 8] = 8'hA5;
        cycle(1, 1, 26'h5, '1, pat, 8'h0, 1, f);
        cycle(1, 0, 26'h5, '0, '0, 8'h3, 1, f);
        idle(LAT + 2);

        // Partial write, then aliased read.
        cycle(1, 1, 26'h5, 64'h1, 512'h11, 8'h0, 1, f);
        cycle(1, 0, 26'h405, '0, '0, 8'h4, 1, f);
        idle(LAT + 2);

        // Backpressure: six read attempts, only the credit-limited ones are taken.
        nfire = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 26'(i), '0, '0, 8'(8'h10 + i), 0, f);
            if (f) nfire++;
        end
        chk("bp_accepted", 512'(nfire), 512'(QD));
        start = cyc;
        fire_cyc = -1;
        for (int i = 0; i < 20 && fire_cyc < 0; i++) begin
            cycle(1, 0, 26'h7, '0, '0, 8'h20, 1, f);
            if (f) fire_cyc = cyc - 1;
        end
        chk("credit_release", 512'(fire_cyc - start), 512'(1));
        idle(QD + LAT + 2);

        // Streaming reads with the consumer always ready.
        nfire = 0; budget = 0;
        while (nfire < 100 && budget < 400) begin
            cycle(1, 0, {16'($urandom), 10'($urandom_range(0, 15))}, '0, '0, 8'(nfire), 1, f);
            if (f) nfire++;
            budget++;
        end
        chk("stream_count", 512'(nfire), 512'(100));
        idle(LAT + 2);

        // Write acknowledgement (no response expected unless the ack feature is built in).
        cycle(1, 1, 26'h9, '1, rnd512(), 8'h7, 1, f);
        idle(LAT + 2);

        // Random mixed traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            d = rnd512();
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {16'($urandom), 10'($urandom_range(0, 15))}, {$urandom, $urandom}, d,
                  8'($urandom), ($urandom_range(0, 3) != 0), f);
        end
        idle(QD + LAT + 4);

        // Reset with three reads in flight.
        for (int i = 0; i < 3; i++) cycle(1, 0, 26'(i + 1), '0, '0, 8'(8'h30 + i), 0, f);
        mem_req_valid = 0;
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 512'(mem_rsp_valid), 512'(0));
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_rsp_tag", 512'(mem_rsp_tag), 512'(0));
        expq.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cycle(1, 0, 26'h2, '0, '0, 8'h55, 1, f);
        idle(LAT + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
